cp0_nested_ctrl: RTL and testbench

- Parametrised coprocessor-0 successor: privileged register file (EHB/STATUS/CAUSE/EPC), synchronous exceptions and NUM_IRQ prioritised interrupt lines.
- Adds a hardware nesting stack of depth NEST_DEPTH, so interrupts preempt lower levels and ERET unwinds one level at a time.
- Optional vectored dispatch.
- Sits beside the pipeline: read in ID, written in EXE; drives PC redirect and pipeline flush.

---
 rtl/cp0_nested_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cp0_nested_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_nested_ctrl.sv
// Privileged CP0 register file with a nesting stack of NEST_DEPTH, prioritised interrupts and optional vectored dispatch.
// Reads return one cycle later on data_r; work happens only when cpu_en=1, and redirect/flush hold through stalls.
module cp0_nested_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              NUM_IRQ    = 3,
    parameter int              NEST_DEPTH = 4,
    parameter int              VECTORED   = 0,
    parameter logic [XLEN-1:0] VEC_STRIDE = 32'h20,
    parameter logic [XLEN-1:0] EHB_RESET  = 32'h24,
    localparam int             LW         = $clog2(NUM_IRQ + 2),
    localparam int             DW         = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_en,
    input  logic [2:0]         cp_oper,
    input  logic [4:0]         addr_r,
    output logic [XLEN-1:0]    data_r,
    input  logic [4:0]         addr_w,
    input  logic [XLEN-1:0]    data_w,
    input  logic [2:0]         exc_cause,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [XLEN-1:0]    except_ret_addr,
    output logic               redirect,
    output logic [XLEN-1:0]    redirect_addr,
    output logic               flush,
    output logic [LW-1:0]      cur_level,
    output logic [DW-1:0]      depth,
    output logic               fatal
);
    localparam int AW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [2:0] OP_MTC  = 3'd1;
    localparam logic [2:0] OP_ERET = 3'd3;
    localparam logic [4:0] REG_EHB    = 5'd3;
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    logic [XLEN-1:0] r_regs    [32];
    logic [XLEN-1:0] r_stk_epc [NEST_DEPTH];
    logic [LW-1:0]   r_stk_lvl [NEST_DEPTH];
    logic [DW-1:0]   r_depth;
    logic [LW-1:0]   r_level;
    logic            r_fatal;
    logic            r_redirect;
    logic            r_flush;
    logic [XLEN-1:0] r_redirect_addr;
    logic [XLEN-1:0] r_data_r;

    logic            w_enable;
    logic            w_full;
    logic            w_adv;
    logic            w_mtc;
    logic            w_exc;
    logic            w_exc_take;
    logic            w_exc_fatal;
    logic            w_irq_take;
    logic            w_take;
    logic            w_eret;
    logic [LW-1:0]   w_irq_lvl;
    logic [LW-1:0]   w_new_lvl;
    logic [AW-1:0]   w_top_idx;
    logic [AW-1:0]   w_push_idx;
    logic [XLEN-1:0] w_top_epc;
    logic [XLEN-1:0] w_epc_view;
    logic [XLEN-1:0] w_ehb;
    logic [XLEN-1:0] w_vec_addr;
    logic [XLEN-1:0] w_ret_epc;
    logic [XLEN-1:0] w_rd_val;

    assign w_enable    = (r_regs[REG_STATUS][15:8] == 8'hFF);
    assign w_full      = (r_depth == DW'(NEST_DEPTH));
    assign w_adv       = cpu_en && !r_fatal;
    assign w_mtc       = cpu_en && (cp_oper == OP_MTC);
    assign w_exc       = w_adv && (exc_cause != 3'd0) && w_enable;
    assign w_exc_take  = w_exc && !w_full;
    assign w_exc_fatal = w_exc && w_full;

    // Ascending scan: the highest asserted line wins.
    always_comb begin
        w_irq_lvl = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq[i]) w_irq_lvl = LW'(i + 1);
        end
    end

    assign w_irq_take = w_adv && !w_exc && w_enable && !w_full && (w_irq_lvl > r_level);
    assign w_take     = w_exc_take || w_irq_take;
    assign w_new_lvl  = w_exc_take ? LW'(NUM_IRQ + 1) : w_irq_lvl;
    // An ERET alongside any take is a flushed instruction and must not unwind.
    assign w_eret     = w_adv && (cp_oper == OP_ERET) && !w_take && !w_exc_fatal;

    assign w_top_idx  = (r_depth == '0) ? '0 : AW'(r_depth - DW'(1));
    assign w_push_idx = AW'(r_depth);
    assign w_top_epc  = r_stk_epc[w_top_idx];
    assign w_epc_view = (r_depth != '0) ? w_top_epc : r_regs[REG_EPC];
    assign w_ehb      = r_regs[REG_EHB];
    assign w_vec_addr = (VECTORED != 0) ? (w_ehb + XLEN'(w_new_lvl) * VEC_STRIDE) : w_ehb;
    assign w_ret_epc  = except_ret_addr + XLEN'(4);

    always_comb begin
        w_rd_val = r_regs[addr_r];
        if (addr_r == REG_CAUSE) begin
            w_rd_val               = '0;
            w_rd_val[2:0]          = r_regs[REG_CAUSE][2:0];
            w_rd_val[8 +: NUM_IRQ] = irq;
            w_rd_val[XLEN-1]       = r_fatal;
        end else if (addr_r == REG_EPC) begin
            w_rd_val = w_epc_view;
        end
        if (w_mtc && (addr_w == addr_r)) w_rd_val = data_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= (i == 3) ? EHB_RESET : '0;
        end else begin
            if (w_mtc) begin
                if (addr_w == REG_CAUSE) begin
                    r_regs[REG_CAUSE][2:0] <= data_w[2:0];
                end else if (addr_w == REG_EPC) begin
                    if (r_depth == '0) r_regs[REG_EPC] <= data_w;
                end else begin
                    r_regs[addr_w] <= data_w;
                end
            end
            if (w_exc_take) r_regs[REG_CAUSE][2:0] <= exc_cause;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                r_stk_epc[i] <= '0;
                r_stk_lvl[i] <= '0;
            end
        end else begin
            if (w_mtc && (addr_w == REG_EPC) && (r_depth != '0)) r_stk_epc[w_top_idx] <= data_w;
            if (w_take) begin
                r_stk_epc[w_push_idx] <= w_ret_epc;
                r_stk_lvl[w_push_idx] <= r_level;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth         <= '0;
            r_level         <= '0;
            r_fatal         <= 1'b0;
            r_redirect      <= 1'b0;
            r_flush         <= 1'b0;
            r_redirect_addr <= '0;
            r_data_r        <= '0;
        end else if (cpu_en) begin
            r_data_r <= w_rd_val;
            if (w_take) begin
                r_redirect      <= 1'b1;
                r_flush         <= 1'b1;
                r_redirect_addr <= w_vec_addr;
                r_level         <= w_new_lvl;
                r_depth         <= r_depth + DW'(1);
            end else if (w_exc_fatal) begin
                r_fatal         <= 1'b1;
                r_redirect      <= 1'b1;
                r_flush         <= 1'b1;
                r_redirect_addr <= w_ehb;
            end else if (w_eret) begin
                r_redirect      <= 1'b1;
                r_flush         <= 1'b0;
                r_redirect_addr <= w_epc_view;
                if (r_depth != '0) begin
                    r_level <= r_stk_lvl[w_top_idx];
                    r_depth <= r_depth - DW'(1);
                end else begin
                    r_level <= '0;
                end
            end else begin
                r_redirect <= 1'b0;
                r_flush    <= 1'b0;
            end
        end
    end

    assign data_r        = r_data_r;
    assign redirect      = r_redirect;
    assign redirect_addr = r_redirect_addr;
    assign flush         = r_flush;
    assign cur_level     = r_level;
    assign depth         = r_depth;
    assign fatal         = r_fatal;
endmodule

// File: tb/tb_cp0_nested_ctrl.sv
// Directed bench: a default instance driven from a vector table plus hand sequences,
// and a NEST_DEPTH=2 / VECTORED=1 instance sharing the same inputs for overflow and vector checks.
module tb_cp0_nested_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_en = 1'b0;
    logic [2:0]  cp_oper = '0;
    logic [4:0]  addr_r = '0, addr_w = '0;
    logic [31:0] data_w = '0;
    logic [2:0]  exc_cause = '0;
    logic [2:0]  irq = '0;
    logic [31:0] except_ret_addr = '0;

    logic [31:0] d1_data_r, d1_raddr, d2_data_r, d2_raddr;
    logic        d1_red, d1_flush, d1_fatal, d2_red, d2_flush, d2_fatal;
    logic [2:0]  d1_lvl, d1_dep, d2_lvl;
    logic [1:0]  d2_dep;

    int n_cmp = 0;
    int n_fail = 0;

    cp0_nested_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .cp_oper(cp_oper),
        .addr_r(addr_r), .data_r(d1_data_r), .addr_w(addr_w), .data_w(data_w),
        .exc_cause(exc_cause), .irq(irq), .except_ret_addr(except_ret_addr),
        .redirect(d1_red), .redirect_addr(d1_raddr), .flush(d1_flush),
        .cur_level(d1_lvl), .depth(d1_dep), .fatal(d1_fatal)
    );

    cp0_nested_ctrl #(.NEST_DEPTH(2), .VECTORED(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .cp_oper(cp_oper),
        .addr_r(addr_r), .data_r(d2_data_r), .addr_w(addr_w), .data_w(data_w),
        .exc_cause(exc_cause), .irq(irq), .except_ret_addr(except_ret_addr),
        .redirect(d2_red), .redirect_addr(d2_raddr), .flush(d2_flush),
        .cur_level(d2_lvl), .depth(d2_dep), .fatal(d2_fatal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [4:0]  ar, aw;
        logic [31:0] dw;
        logic [2:0]  exc, irqv;
        logic [31:0] ra;
        logic        red;
        logic [31:0] raddr;
        logic        fl_care, fl;
        logic [2:0]  lvl, dep;
        logic [31:0] dr;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic en, input logic [2:0] op, input logic [4:0] ar,
                                input logic [4:0] aw, input logic [31:0] dw, input logic [2:0] exc,
                                input logic [2:0] irqv, input logic [31:0] ra, input logic red,
                                input logic [31:0] raddr, input logic fl_care, input logic fl,
                                input logic [2:0] lvl, input logic [2:0] dep, input logic [31:0] dr);
        vec_t v;
        v.en = en; v.op = op; v.ar = ar; v.aw = aw; v.dw = dw; v.exc = exc; v.irqv = irqv;
        v.ra = ra; v.red = red; v.raddr = raddr; v.fl_care = fl_care; v.fl = fl;
        v.lvl = lvl; v.dep = dep; v.dr = dr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic [2:0] op, input logic [4:0] ar,
                        input logic [4:0] aw, input logic [31:0] dw, input logic [2:0] exc,
                        input logic [2:0] irqv, input logic [31:0] ra);
        cpu_en = en; cp_oper = op; addr_r = ar; addr_w = aw; data_w = dw;
        exc_cause = exc; irq = irqv; except_ret_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cpu_en = 1'b0; cp_oper = '0; addr_r = '0; addr_w = '0; data_w = '0;
        exc_cause = '0; irq = '0; except_ret_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(1,1,12,12,32'hFF00,0,0,0,          0,32'h0,  1,0,0,0,32'hFF00);
        tbl[1]  = mk(1,0,3,0,0,2,0,32'h100,             1,32'h24, 1,1,4,1,32'h24);
        tbl[2]  = mk(1,0,13,0,0,0,0,0,                  0,32'h24, 1,0,4,1,32'h2);
        tbl[3]  = mk(1,0,14,0,0,0,0,0,                  0,32'h24, 1,0,4,1,32'h104);
        tbl[4]  = mk(1,3,14,0,0,0,0,0,                  1,32'h104,0,0,0,0,32'h104);
        tbl[5]  = mk(1,0,0,0,0,0,3'b001,32'h200,        1,32'h24, 1,1,1,1,32'h0);
        tbl[6]  = mk(1,0,14,0,0,0,3'b101,32'h300,       1,32'h24, 1,1,3,2,32'h204);
        tbl[7]  = mk(1,3,14,0,0,0,0,0,                  1,32'h304,0,0,1,1,32'h304);
        tbl[8]  = mk(1,3,14,0,0,0,0,0,                  1,32'h204,0,0,0,0,32'h204);
        tbl[9]  = mk(1,1,14,14,32'h500,0,0,0,           0,32'h204,1,0,0,0,32'h500);
        tbl[10] = mk(1,3,14,0,0,0,0,0,                  1,32'h500,0,0,0,0,32'h500);
        tbl[11] = mk(1,3,13,0,0,0,3'b001,32'h600,       1,32'h24, 1,1,1,1,32'h102);
        tbl[12] = mk(1,0,13,0,0,0,3'b001,0,             0,32'h24, 1,0,1,1,32'h102);
        tbl[13] = mk(1,1,3,3,32'h800,4,0,32'hFFFF_FFFC, 1,32'h24, 1,1,4,2,32'h800);
        tbl[14] = mk(1,0,14,0,0,0,0,0,                  0,32'h24, 1,0,4,2,32'h0);
        tbl[15] = mk(1,1,0,13,32'hFFFF_FFF5,0,0,0,      0,32'h24, 1,0,4,2,32'h0);
        tbl[16] = mk(1,0,13,0,0,0,0,0,                  0,32'h24, 1,0,4,2,32'h5);
        tbl[17] = mk(1,3,3,0,0,0,0,0,                   1,32'h0,  0,0,1,1,32'h800);
        tbl[18] = mk(1,3,3,0,0,0,0,0,                   1,32'h604,0,0,0,0,32'h800);
        tbl[19] = mk(1,1,12,12,32'h0,0,0,0,             0,32'h604,1,0,0,0,32'h0);
        tbl[20] = mk(1,0,12,0,0,1,0,32'h900,            0,32'h604,1,0,0,0,32'h0);
        tbl[21] = mk(0,1,12,12,32'hFF00,0,3'b001,0,     0,32'h604,1,0,0,0,32'h0);
        tbl[22] = mk(1,0,12,0,0,0,0,0,                  0,32'h604,1,0,0,0,32'h0);

        do_reset();
        chk("rst_data_r", d1_data_r, 0);
        chk("rst_redirect", {31'b0, d1_red}, 0);
        chk("rst_raddr", d1_raddr, 0);
        chk("rst_flush", {31'b0, d1_flush}, 0);
        chk("rst_level", {29'b0, d1_lvl}, 0);
        chk("rst_depth", {29'b0, d1_dep}, 0);
        chk("rst_fatal", {31'b0, d1_fatal}, 0);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].en, tbl[i].op, tbl[i].ar, tbl[i].aw, tbl[i].dw, tbl[i].exc, tbl[i].irqv, tbl[i].ra);
            chk($sformatf("v%0d_redirect", i), {31'b0, d1_red}, {31'b0, tbl[i].red});
            chk($sformatf("v%0d_raddr", i), d1_raddr, tbl[i].raddr);
            if (tbl[i].fl_care) chk($sformatf("v%0d_flush", i), {31'b0, d1_flush}, {31'b0, tbl[i].fl});
            chk($sformatf("v%0d_level", i), {29'b0, d1_lvl}, {29'b0, tbl[i].lvl});
            chk($sformatf("v%0d_depth", i), {29'b0, d1_dep}, {29'b0, tbl[i].dep});
            chk($sformatf("v%0d_data_r", i), d1_data_r, tbl[i].dr);
        end

        // Redirect/flush held across a three-cycle stall, released on the next advance.
        step(1,1,0,12,32'hFF00,0,0,0);
        step(1,0,0,0,0,0,3'b010,32'h700);
        chk("stall_take_raddr", d1_raddr, 32'h800);
        chk("stall_take_level", {29'b0, d1_lvl}, 2);
        for (int k = 0; k < 3; k++) begin
            step(0,0,0,0,0,0,0,0);
            chk($sformatf("stall%0d_redirect", k), {31'b0, d1_red}, 1);
            chk($sformatf("stall%0d_flush", k), {31'b0, d1_flush}, 1);
        end
        step(1,0,0,0,0,0,0,0);
        chk("unstall_redirect", {31'b0, d1_red}, 0);
        chk("unstall_flush", {31'b0, d1_flush}, 0);

        // Fill the four-deep stack, then overflow it with one more exception.
        step(1,0,0,0,0,0,3'b100,32'h10);
        chk("fill_level3", {29'b0, d1_lvl}, 3);
        step(1,0,0,0,0,1,0,32'h20);
        chk("fill_depth3", {29'b0, d1_dep}, 3);
        step(1,0,0,0,0,1,0,32'h30);
        chk("fill_depth4", {29'b0, d1_dep}, 4);
        step(1,0,0,0,0,1,0,32'h40);
        chk("ovf_fatal", {31'b0, d1_fatal}, 1);
        chk("ovf_redirect", {31'b0, d1_red}, 1);
        chk("ovf_raddr", d1_raddr, 32'h800);
        chk("ovf_depth", {29'b0, d1_dep}, 4);
        step(1,0,13,0,0,0,0,0);
        chk("ovf_cause31", {31'b0, d1_data_r[31]}, 1);
        chk("ovf_redirect_clear", {31'b0, d1_red}, 0);
        step(1,3,0,0,0,1,0,0);
        chk("fatal_blocks_redirect", {31'b0, d1_red}, 0);
        chk("fatal_sticky", {31'b0, d1_fatal}, 1);
        chk("fatal_level", {29'b0, d1_lvl}, 4);

        // Asynchronous reset while a redirect is asserted.
        do_reset();
        step(1,1,0,12,32'hFF00,0,0,0);
        step(1,0,0,0,0,0,3'b001,0);
        chk("pre_arst_redirect", {31'b0, d1_red}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_redirect", {31'b0, d1_red}, 0);
        chk("arst_flush", {31'b0, d1_flush}, 0);
        chk("arst_raddr", d1_raddr, 0);
        chk("arst_level", {29'b0, d1_lvl}, 0);
        chk("arst_depth", {29'b0, d1_dep}, 0);
        chk("arst_fatal", {31'b0, d1_fatal}, 0);
        chk("arst_data_r", d1_data_r, 0);
        #2 rst_n = 1'b1;
        step(1,0,3,0,0,0,0,0);
        chk("arst_ehb", d1_data_r, 32'h24);

        // Two-deep, vectored instance: full stack leaves a higher irq pending, then overflow.
        do_reset();
        step(1,1,0,12,32'hFF00,0,0,0);
        step(1,0,0,0,0,0,3'b001,0);
        chk("v2_irq0_raddr", d2_raddr, 32'h44);
        chk("v2_irq0_level", {29'b0, d2_lvl}, 1);
        step(1,0,0,0,0,0,3'b011,0);
        chk("v2_irq1_raddr", d2_raddr, 32'h64);
        chk("v2_irq1_depth", {30'b0, d2_dep}, 2);
        step(1,0,0,0,0,0,3'b111,0);
        chk("v2_full_noredirect", {31'b0, d2_red}, 0);
        chk("v2_full_level", {29'b0, d2_lvl}, 2);
        step(1,0,13,0,0,0,3'b111,0);
        chk("v2_pending_cause", d2_data_r, 32'h700);
        step(1,0,0,0,0,2,0,0);
        chk("v2_ovf_fatal", {31'b0, d2_fatal}, 1);
        chk("v2_ovf_redirect", {31'b0, d2_red}, 1);
        chk("v2_ovf_raddr", d2_raddr, 32'h24);
        chk("v2_ovf_depth", {30'b0, d2_dep}, 2);
        step(1,0,13,0,0,0,0,0);
        chk("v2_cause31", {31'b0, d2_data_r[31]}, 1);

        do_reset();
        step(1,1,0,12,32'hFF00,0,0,0);
        step(1,1,0,3,32'h1000,0,0,0);
        step(1,0,0,0,0,0,3'b010,0);
        chk("v2_vec_raddr", d2_raddr, 32'h1040);
        chk("v2_vec_level", {29'b0, d2_lvl}, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
